// File: rtl/cook_timer.sv
// Microwave cook-time countdown: MM:SS BCD key entry, per-second decrement while the
// magnetron is on, and a registered done flag that drops the magnetron latch at 00:00.
module cook_timer #(
  parameter int unsigned TICKS_PER_SEC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clearn,
  input  logic       mag_on,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic       timer_done,
  output logic       done_pulse,
  output logic       sec_tick,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PrescTerm = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {StIdle, StSet, StRun, StPause, StDone} state_e;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d, cnt_dec;
  logic [PW-1:0] presc_q, presc_d;
  logic          timer_done_q, timer_done_d;
  logic          done_pulse_q, done_pulse_d;
  logic          sec_tick_q, sec_tick_d;
  logic          key_ok;

  assign key_ok = key_valid && (key_digit <= 4'd9);

  // BCD decrement with borrow; only used when the count is nonzero.
  always_comb begin
    cnt_dec = cnt_q;
    if (cnt_q[3:0] != 4'd0) begin
      cnt_dec[3:0] = cnt_q[3:0] - 4'd1;
    end else if (cnt_q[7:4] != 4'd0) begin
      cnt_dec[3:0] = 4'd9;
      cnt_dec[7:4] = cnt_q[7:4] - 4'd1;
    end else begin
      cnt_dec[7:0] = 8'h59;
      if (cnt_q[11:8] != 4'd0) begin
        cnt_dec[11:8] = cnt_q[11:8] - 4'd1;
      end else begin
        cnt_dec[11:8]  = 4'd9;
        cnt_dec[15:12] = cnt_q[15:12] - 4'd1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    presc_d      = presc_q;
    done_pulse_d = 1'b0;
    sec_tick_d   = 1'b0;
    if (!clearn) begin
      state_d = StIdle;
      cnt_d   = 16'h0000;
      presc_d = '0;
    end else if (mag_on) begin
      if (cnt_q != 16'h0000) begin
        state_d = StRun;
        if (presc_q == PrescTerm) begin
          presc_d    = '0;
          cnt_d      = cnt_dec;
          sec_tick_d = 1'b1;
          if (cnt_dec == 16'h0000) begin
            state_d      = StDone;
            done_pulse_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end else begin
        presc_d = '0;
      end
    end else if (key_ok) begin
      cnt_d   = {cnt_q[11:0], key_digit};
      presc_d = '0;
      if (cnt_d != 16'h0000) begin
        state_d = StSet;
      end else if (state_q != StDone) begin
        state_d = StIdle;
      end
    end else if (state_q == StRun) begin
      state_d = StPause;
    end
    timer_done_d = (cnt_d == 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 16'h0000;
      presc_q      <= '0;
      timer_done_q <= 1'b1;
      done_pulse_q <= 1'b0;
      sec_tick_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      presc_q      <= presc_d;
      timer_done_q <= timer_done_d;
      done_pulse_q <= done_pulse_d;
      sec_tick_q   <= sec_tick_d;
    end
  end

  assign timer_done = timer_done_q;
  assign done_pulse = done_pulse_q;
  assign sec_tick   = sec_tick_q;
  assign min_tens   = cnt_q[15:12];
  assign min_ones   = cnt_q[11:8];
  assign sec_tens   = cnt_q[7:4];
  assign sec_ones   = cnt_q[3:0];

endmodule

// File: tb/tb_cook_timer.sv
// Directed, table-driven bench for cook_timer with a 4-cycle second.
module tb_cook_timer;

  logic       clk = 1'b0;
  logic       rst, clearn, mag_on, key_valid;
  logic [3:0] key_digit;
  logic       timer_done, done_pulse, sec_tick;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, clr, mag, kv;
    logic [3:0]  kd;
    logic [15:0] cnt;
    logic        td, dp, st;
  } vec_t;

  vec_t vecs[$];

  cook_timer #(.TICKS_PER_SEC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .clearn     (clearn),
    .mag_on     (mag_on),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .timer_done (timer_done),
    .done_pulse (done_pulse),
    .sec_tick   (sec_tick),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] count();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic add(input logic r, c, m, kv, input logic [3:0] kd, input logic [15:0] cnt,
                     input logic td, dp, st);
    vec_t v;
    v.rst = r; v.clr = c; v.mag = m; v.kv = kv; v.kd = kd;
    v.cnt = cnt; v.td = td; v.dp = dp; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, c, m, kv, input logic [3:0] kd);
    rst = r; clearn = c; mag_on = m; key_valid = kv; key_digit = kd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; clearn = 1'b1; mag_on = 1'b0; key_valid = 1'b0; key_digit = 4'd0;

    // Entry: 01:23, invalid digit ignored
    add(1, 1, 0, 0, 0, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 1, 1, 16'h0001, 0, 0, 0);
    add(0, 1, 0, 1, 2, 16'h0012, 0, 0, 0);
    add(0, 1, 0, 1, 3, 16'h0123, 0, 0, 0);
    add(0, 1, 0, 1, 12, 16'h0123, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'h0123, 0, 0, 0);
    // Countdown with minute borrow from 01:00
    add(0, 0, 0, 0, 0, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 1, 1, 16'h0001, 0, 0, 0);
    add(0, 1, 0, 1, 0, 16'h0010, 0, 0, 0);
    add(0, 1, 0, 1, 0, 16'h0100, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 16'h0100, 0, 0, 0);
    add(0, 1, 1, 0, 0, 16'h0059, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 16'h0059, 0, 0, 0);
    add(0, 1, 1, 0, 0, 16'h0058, 0, 0, 1);
    // Completion from 00:02, then hold with nothing further
    add(0, 0, 0, 0, 0, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 1, 2, 16'h0002, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 16'h0002, 0, 0, 0);
    add(0, 1, 1, 0, 0, 16'h0001, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 16'h0001, 0, 0, 0);
    add(0, 1, 1, 0, 0, 16'h0000, 1, 1, 1);
    for (int i = 0; i < 20; i++) add(0, 1, 1, 0, 0, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 1, 0, 16'h0000, 1, 0, 0);
    // Pause/resume keeps partial second; key while running ignored
    add(0, 0, 0, 0, 0, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 1, 5, 16'h0005, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 16'h0005, 0, 0, 0);
    add(0, 1, 1, 0, 0, 16'h0004, 0, 0, 1);
    add(0, 1, 1, 1, 7, 16'h0004, 0, 0, 0);
    add(0, 1, 1, 0, 0, 16'h0004, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 0, 16'h0004, 0, 0, 0);
    add(0, 1, 1, 0, 0, 16'h0004, 0, 0, 0);
    add(0, 1, 1, 0, 0, 16'h0003, 0, 0, 1);
    // Clear on what would be a decrement edge, with a key strobe
    add(0, 0, 0, 0, 0, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 1, 3, 16'h0003, 0, 0, 0);
    add(0, 1, 0, 1, 0, 16'h0030, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 16'h0030, 0, 0, 0);
    add(0, 0, 1, 1, 5, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 0, 0, 16'h0000, 1, 0, 0);
    // Reset beats everything on the final decrement edge of 00:01
    add(0, 1, 0, 1, 1, 16'h0001, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 16'h0001, 0, 0, 0);
    add(1, 0, 1, 1, 9, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 1, 1, 16'h0001, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 16'h0001, 0, 0, 0);
    add(0, 1, 1, 0, 0, 16'h0000, 1, 1, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].clr, vecs[i].mag, vecs[i].kv, vecs[i].kd);
      check($sformatf("v%0d_count", i), count(), vecs[i].cnt);
      check($sformatf("v%0d_timer_done", i), 16'(timer_done), 16'(vecs[i].td));
      check($sformatf("v%0d_done_pulse", i), 16'(done_pulse), 16'(vecs[i].dp));
      check($sformatf("v%0d_sec_tick", i), 16'(sec_tick), 16'(vecs[i].st));
    end

    // 10:00 borrows through both seconds digits and min_ones
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);
    check("load_1000", count(), 16'h1000);
    n = 0;
    do begin
      step(0, 1, 1, 0, 0);
      n++;
    end while (!sec_tick && n < 12);
    check("tick_latency", 16'(n), 16'd4);
    check("borrow_1000", count(), 16'h0959);

    // Seconds above 59 are kept as keyed
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 1, 9);
    step(0, 1, 0, 1, 0);
    check("load_0190", count(), 16'h0190);
    n = 0;
    do begin
      step(0, 1, 1, 0, 0);
      n++;
    end while (!sec_tick && n < 12);
    check("tick_latency_0190", 16'(n), 16'd4);
    check("dec_0190", count(), 16'h0189);
    check("running_done_low", 16'(timer_done), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
